// File: rtl/cbudn_mod_if.sv
// cbudn_mod_if: control, data and carry-chain signals of one counter stage
interface cbudn_mod_if #(
  parameter int WIDTH = 4
);
  logic             PS;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             EN;
  logic             CAI;
  logic             UP;
  logic [WIDTH-1:0] Q;
  logic             CAO;
  logic             WRAP;
  modport master (output PS, LD, D, EN, CAI, UP, input Q, CAO, WRAP);
  modport slave  (input PS, LD, D, EN, CAI, UP, output Q, CAO, WRAP);
endinterface

// File: rtl/cbudn_mod.sv
// cbudn_mod: up/down modulus counter with preset, clamped load, wrap/saturate and carry chain
module cbudn_mod #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0
) (
  input logic         CLK,
  input logic         CDN,
  cbudn_mod_if.slave  bus
);
  // MODULUS-1 always fits in WIDTH bits, even when MODULUS is 2^WIDTH
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d, up_v, dn_v;
  logic             wrap_q, wrap_d, tc, cnt;
  always_comb begin
    tc     = bus.UP ? (q_q == MAX_Q) : (q_q == '0);
    cnt    = bus.CAI & bus.EN;
    up_v   = tc ? (SATURATE ? q_q : '0) : q_q + WIDTH'(1);
    dn_v   = tc ? (SATURATE ? q_q : MAX_Q) : q_q - WIDTH'(1);
    q_d    = bus.PS ? MAX_Q :
             bus.LD ? ((bus.D > MAX_Q) ? MAX_Q : bus.D) :
             cnt    ? (bus.UP ? up_v : dn_v) : q_q;
    wrap_d = ~bus.PS & ~bus.LD & cnt & tc;
  end
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.Q    = q_q;
  assign bus.CAO  = cnt & tc;
  assign bus.WRAP = wrap_q;
endmodule

// File: tb/tb_cbudn_mod.sv
// tb_cbudn_mod: directed and random checks of wrap, saturate, cascade and binary stages
module tb_cbudn_mod;
  logic CLK = 1'b0;
  logic CDN = 1'b0;
  always #5 CLK = ~CLK;

  logic       ps = 0, ld = 0, en = 0, cai = 0, up = 1;
  logic [3:0] d = 0;
  logic       ps_h = 0, ld_h = 0;
  logic [3:0] d_h = 0;
  int compared = 0, mismatched = 0;

  cbudn_mod_if #(.WIDTH(4)) w_if ();
  cbudn_mod_if #(.WIDTH(4)) s_if ();
  cbudn_mod_if #(.WIDTH(4)) h_if ();
  cbudn_mod_if #(.WIDTH(3)) b_if ();

  cbudn_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_w (.CLK(CLK), .CDN(CDN), .bus(w_if.slave));
  cbudn_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s (.CLK(CLK), .CDN(CDN), .bus(s_if.slave));
  cbudn_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_h (.CLK(CLK), .CDN(CDN), .bus(h_if.slave));
  cbudn_mod #(.WIDTH(3), .MODULUS(8),  .SATURATE(1'b0)) u_b (.CLK(CLK), .CDN(CDN), .bus(b_if.slave));

  assign w_if.PS = ps;   assign w_if.LD = ld;   assign w_if.D = d;        assign w_if.EN = en;
  assign w_if.CAI = cai; assign w_if.UP = up;
  assign s_if.PS = ps;   assign s_if.LD = ld;   assign s_if.D = d;        assign s_if.EN = en;
  assign s_if.CAI = cai; assign s_if.UP = up;
  assign b_if.PS = ps;   assign b_if.LD = ld;   assign b_if.D = d[2:0];   assign b_if.EN = en;
  assign b_if.CAI = cai; assign b_if.UP = up;
  assign h_if.PS = ps_h; assign h_if.LD = ld_h; assign h_if.D = d_h;      assign h_if.EN = en;
  assign h_if.CAI = w_if.CAO; assign h_if.UP = up;

  logic [3:0] qo [4];
  logic       co [4];
  logic       wo [4];
  assign qo[0] = w_if.Q; assign qo[1] = s_if.Q; assign qo[2] = h_if.Q; assign qo[3] = {1'b0, b_if.Q};
  assign co[0] = w_if.CAO; assign co[1] = s_if.CAO; assign co[2] = h_if.CAO; assign co[3] = b_if.CAO;
  assign wo[0] = w_if.WRAP; assign wo[1] = s_if.WRAP; assign wo[2] = h_if.WRAP; assign wo[3] = b_if.WRAP;

  int md [4] = '{10, 10, 10, 8};
  int st [4] = '{0, 1, 0, 0};
  int mq [4] = '{0, 0, 0, 0};
  int mw [4] = '{0, 0, 0, 0};
  int ecao [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin mq[i] = 0; mw[i] = 0; end
  endtask

  // one clock: check carry-outs before the edge, then state and wrap after it
  task automatic tick();
    int nq [4];
    int nw [4];
    int m, c, tc, p, l, dv;
    #1;
    for (int i = 0; i < 4; i++) begin
      m  = md[i];
      c  = (i == 2) ? ecao[0] : int'(cai);
      p  = (i == 2) ? int'(ps_h) : int'(ps);
      l  = (i == 2) ? int'(ld_h) : int'(ld);
      dv = (i == 2) ? int'(d_h) : (i == 3) ? int'(d) % 8 : int'(d);
      tc = up ? int'(mq[i] == m - 1) : int'(mq[i] == 0);
      ecao[i] = c & int'(en) & tc;
      chk($sformatf("cao%0d", i), 32'(co[i]), 32'(ecao[i]));
      if (p) nq[i] = m - 1;
      else if (l) nq[i] = (dv < m) ? dv : m - 1;
      else if (c && en) begin
        if (st[i]) nq[i] = up ? ((mq[i] + 1 < m) ? mq[i] + 1 : m - 1) : ((mq[i] > 0) ? mq[i] - 1 : 0);
        else       nq[i] = up ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
      end else nq[i] = mq[i];
      nw[i] = (!p && !l && c && en && tc) ? 1 : 0;
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      mq[i] = nq[i];
      mw[i] = nw[i];
      chk($sformatf("q%0d", i), 32'(qo[i]), 32'(mq[i]));
      chk($sformatf("wrap%0d", i), 32'(wo[i]), 32'(mw[i]));
    end
  endtask

  task automatic async_clear();
    #2 CDN = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clr_q%0d", i), 32'(qo[i]), 0);
      chk($sformatf("clr_wrap%0d", i), 32'(wo[i]), 0);
    end
    #1 CDN = 1'b1;
  endtask

  task automatic idle();
    ps = 0; ld = 0; en = 0; cai = 0; ps_h = 0; ld_h = 0;
  endtask

  initial begin
    int hw;
    int sq [4] = '{1, 0, 0, 0};
    int sw [4] = '{0, 0, 1, 1};
    #3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_q%0d", i), 32'(qo[i]), 0);
      chk($sformatf("rst_wrap%0d", i), 32'(wo[i]), 0);
    end
    CDN = 1'b1;
    @(posedge CLK); #1;
    // load 7, then clear asynchronously mid-cycle and hold with EN=0
    ld = 1; d = 7; tick();
    chk("pre_clr_q", 32'(qo[0]), 7);
    ld = 0; async_clear();
    idle(); tick();
    chk("hold_after_clr", 32'(qo[0]), 0);
    // up wrap and BCD cascade over 100 edges
    en = 1; cai = 1; up = 1; hw = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k <= 10) chk("upwrap_q", 32'(qo[0]), 32'(k % 10));
      if (k == 10) chk("upwrap_wrap", 32'(wo[0]), 1);
      chk("bcd_hi", 32'(qo[2]), 32'((k / 10) % 10));
      hw += int'(wo[2]);
    end
    chk("bcd_lo_end", 32'(qo[0]), 0);
    chk("bcd_hi_wraps", 32'(hw), 1);
    // down saturate from 2
    idle(); ld = 1; d = 2; tick();
    ld = 0; en = 1; cai = 1; up = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dsat_q", 32'(qo[1]), 32'(sq[k]));
      chk("dsat_wrap", 32'(wo[1]), 32'(sw[k]));
    end
    // clamp and priority
    idle(); ld = 1; d = 13; tick();
    chk("clamp", 32'(qo[0]), 9);
    ps = 1; ld = 1; d = 3; tick();
    chk("ps_over_ld", 32'(qo[0]), 9);
    ps = 0; ld = 1; en = 1; cai = 1; up = 1; d = 4; tick();
    chk("ld_over_cnt", 32'(qo[0]), 4);
    // full-range binary down from 0
    idle(); async_clear();
    en = 1; cai = 1; up = 0; tick();
    chk("bin_q", 32'(qo[3]), 7);
    chk("bin_wrap", 32'(wo[3]), 1);
    // random mix across all stages
    for (int k = 0; k < 400; k++) begin
      ps   = ($urandom_range(0, 15) == 0);
      ld   = ($urandom_range(0, 7) == 0);
      d    = 4'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      cai  = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom);
      ps_h = ($urandom_range(0, 31) == 0);
      ld_h = ($urandom_range(0, 31) == 0);
      d_h  = 4'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
